// File: rtl/ifetch_seq_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// word width and default PC parameters.
package ifetch_seq_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0040_0000;
  localparam logic [XLEN-1:0] DEFAULT_PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_seq_if.sv
// Fetch-side bus bundle: instruction-memory req/ack handshake plus the
// one-entry valid/ready buffer presented to decode.
interface ifetch_seq_if;
  import ifetch_seq_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;

  // Sequencer side.
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, instr_ready
  );

  // Memory and decode side.
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, instr_ready
  );

endinterface

// File: rtl/ifetch_seq.sv
// Instruction-fetch sequencer: drives the external PC register, fetches the
// word at the PC and buffers it for decode; execute redirects take priority.
module ifetch_seq
  import ifetch_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_cur,
  output logic            pc_ena,
  output logic [XLEN-1:0] pc_next,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  ifetch_seq_if.master    fetch
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;

  logic            imem_req_c;
  logic [XLEN-1:0] imem_addr_c;
  logic            instr_valid_c;

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    pc_ena        = 1'b0;
    pc_next       = '0;
    imem_req_c    = 1'b0;
    imem_addr_c   = '0;
    instr_valid_c = 1'b0;

    // Reset forces every decoded output low; the register update is in the ff.
    if (!rst) begin
      unique case (state_q)
        ST_BOOT: begin
          pc_ena  = 1'b1;
          pc_next = RESET_PC;
          state_d = ST_REQ;
        end

        ST_REQ: begin
          imem_req_c  = 1'b1;
          imem_addr_c = pc_cur;
          if (redirect_valid) begin
            // A word acked in the same cycle is dropped.
            pc_ena  = 1'b1;
            pc_next = word_align(redirect_target);
            state_d = ST_REQ;
          end else if (fetch.imem_ack) begin
            instr_d    = fetch.imem_rdata;
            instr_pc_d = pc_cur;
            pc_ena     = 1'b1;
            pc_next    = pc_cur + PC_STEP;
            state_d    = ST_HOLD;
          end
        end

        ST_HOLD: begin
          instr_valid_c = 1'b1;
          if (redirect_valid) begin
            pc_ena  = 1'b1;
            pc_next = word_align(redirect_target);
            state_d = ST_REQ;
          end else if (fetch.instr_ready) begin
            state_d = ST_REQ;
          end
        end

        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign fetch.imem_req    = imem_req_c;
  assign fetch.imem_addr   = imem_addr_c;
  assign fetch.instr_valid = instr_valid_c;
  assign fetch.instr       = instr_q;
  assign fetch.instr_pc    = instr_pc_q;

endmodule
